// File: rtl/seg_pkg.sv
// Shared glyph table and helpers for the hexadecimal 7-segment display controller.
// Segment order is {a,b,c,d,e,f,g,dp}; glyph constants are active-high.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [7:0] GLYPH_0 = 8'hFC;
  localparam logic [7:0] GLYPH_1 = 8'h60;
  localparam logic [7:0] GLYPH_2 = 8'hDA;
  localparam logic [7:0] GLYPH_3 = 8'hF2;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'hB6;
  localparam logic [7:0] GLYPH_6 = 8'hBE;
  localparam logic [7:0] GLYPH_7 = 8'hE0;
  localparam logic [7:0] GLYPH_8 = 8'hFE;
  localparam logic [7:0] GLYPH_9 = 8'hF6;
  localparam logic [7:0] GLYPH_A = 8'hEE;
  localparam logic [7:0] GLYPH_B = 8'h3E;
  localparam logic [7:0] GLYPH_C = 8'h9C;
  localparam logic [7:0] GLYPH_D = 8'h7A;
  localparam logic [7:0] GLYPH_E = 8'h9E;
  localparam logic [7:0] GLYPH_F = 8'h8E;

  // Returns active-low segments with the decimal point merged into bit 0.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nibble, input logic dp);
    logic [7:0] g;
    case (nibble)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return ~{g[7:1], dp};
  endfunction

endpackage

// File: rtl/seg_hex_glyph.sv
// Combinational single-digit decoder: hex nibble to active-low segments.
// When off is set only the decimal point can light (leading-zero suppression).
module seg_hex_glyph
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       off,
  output logic [7:0] seg
);

  always_comb begin
    if (off) begin
      seg = {7'h7F, ~dp};
    end else begin
      seg = hex_glyph(nibble, dp);
    end
  end

endmodule

// File: rtl/seg_disp_ctrl.sv
// Multi-digit hex 7-segment display controller with static or multiplexed scan drive.
// Frames arrive over valid/ready; scan mode double-buffers so a frame never tears.
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN      = 0,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_blank,
  input  logic [DIGITS-1:0]     load_blink,
  input  logic                  load_lz,
  output logic [8*DIGITS-1:0]   seg_out,
  output logic [7:0]            seg_scan,
  output logic [DIGITS-1:0]     an_out
);

  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Active (displayed) frame
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   blank_q;
  logic [DIGITS-1:0]   blink_q;
  logic                lz_q;

  logic [BW-1:0]       blink_cnt_q;
  logic                phase_q;
  logic [DIGITS-1:0]   supp;
  logic [DIGITS-1:0]   dark;
  logic                lz_run;
  logic                xfer;

  assign xfer = load_valid & load_ready;

  // Free-running blink timebase; frame loads never disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // A digit is suppressed while it and every higher digit hold zero; blanking is ignored here.
  always_comb begin
    lz_run = lz_q;
    supp   = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      lz_run  = lz_run & (data_q[4*i +: 4] == 4'h0);
      supp[i] = lz_run;
    end
    supp[0] = 1'b0;
  end

  assign dark = blank_q | (blink_q & {DIGITS{phase_q}});

  if (SCAN == 0) begin : g_static

    logic [8*DIGITS-1:0] glyph;
    logic [8*DIGITS-1:0] seg_d;
    logic [8*DIGITS-1:0] seg_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      seg_hex_glyph u_glyph (
        .nibble (data_q[4*g +: 4]),
        .dp     (dp_q[g]),
        .off    (supp[g]),
        .seg    (glyph[8*g +: 8])
      );
      assign seg_d[8*g +: 8] = dark[g] ? SEG_OFF : glyph[8*g +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        dp_q    <= '0;
        blank_q <= '1;
        blink_q <= '0;
        lz_q    <= 1'b0;
        seg_q   <= '1;
      end else begin
        if (xfer) begin
          data_q  <= load_data;
          dp_q    <= load_dp;
          blank_q <= load_blank;
          blink_q <= load_blink;
          lz_q    <= load_lz;
        end
        seg_q <= seg_d;
      end
    end

    assign load_ready = ~rst;
    assign seg_out    = seg_q;
    assign seg_scan   = SEG_OFF;
    assign an_out     = '1;

  end else begin : g_scan

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic                pending_q;
    logic [4*DIGITS-1:0] sh_data_q;
    logic [DIGITS-1:0]   sh_dp_q;
    logic [DIGITS-1:0]   sh_blank_q;
    logic [DIGITS-1:0]   sh_blink_q;
    logic                sh_lz_q;
    logic [7:0]          seg_scan_q;
    logic [DIGITS-1:0]   an_q;

    logic [3:0]          cur_nibble;
    logic                cur_dp;
    logic                cur_supp;
    logic                cur_dark;
    logic [7:0]          cur_glyph;
    logic [DIGITS-1:0]   an_d;
    logic                dwell_wrap;
    logic                frame_end;

    always_comb begin
      cur_nibble = '0;
      cur_dp     = 1'b0;
      cur_supp   = 1'b0;
      cur_dark   = 1'b0;
      an_d       = '1;
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (idx_q == IW'(i)) begin
          cur_nibble = data_q[4*i +: 4];
          cur_dp     = dp_q[i];
          cur_supp   = supp[i];
          cur_dark   = dark[i];
          an_d[i]    = 1'b0;
        end
      end
    end

    seg_hex_glyph u_glyph (
      .nibble (cur_nibble),
      .dp     (cur_dp),
      .off    (cur_supp),
      .seg    (cur_glyph)
    );

    assign dwell_wrap = (cnt_q == SW'(SCAN_DIV - 1));
    assign frame_end  = dwell_wrap && (idx_q == IW'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q      <= '0;
        idx_q      <= '0;
        pending_q  <= 1'b0;
        data_q     <= '0;
        dp_q       <= '0;
        blank_q    <= '1;
        blink_q    <= '0;
        lz_q       <= 1'b0;
        sh_data_q  <= '0;
        sh_dp_q    <= '0;
        sh_blank_q <= '1;
        sh_blink_q <= '0;
        sh_lz_q    <= 1'b0;
        seg_scan_q <= SEG_OFF;
        an_q       <= '1;
      end else begin
        if (dwell_wrap) begin
          cnt_q <= '0;
          idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        // Swap only at the frame boundary; a transfer on this same edge lands in the shadow.
        if (frame_end && pending_q) begin
          data_q    <= sh_data_q;
          dp_q      <= sh_dp_q;
          blank_q   <= sh_blank_q;
          blink_q   <= sh_blink_q;
          lz_q      <= sh_lz_q;
          pending_q <= 1'b0;
        end
        if (xfer) begin
          sh_data_q  <= load_data;
          sh_dp_q    <= load_dp;
          sh_blank_q <= load_blank;
          sh_blink_q <= load_blink;
          sh_lz_q    <= load_lz;
          pending_q  <= 1'b1;
        end
        seg_scan_q <= cur_dark ? SEG_OFF : cur_glyph;
        an_q       <= an_d;
      end
    end

    assign load_ready = ~rst & ~pending_q;
    assign seg_out    = '1;
    assign seg_scan   = seg_scan_q;
    assign an_out     = an_q;

  end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Self-checking bench: static 4-digit, scanned 4-digit and scanned 1-digit controllers
// checked against directed vectors and a digit-level reference model.
module tb_seg_disp_ctrl;

  localparam int S_BD = 4;
  localparam int C_SD = 3;
  localparam int C_BD = 5;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic        lz;
  } frame_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
    logic [31:0] exp;
  } vec_t;

  localparam frame_t RST_FRAME = '{data: 16'h0, dp: 4'h0, blank: 4'hF, blink: 4'h0, lz: 1'b0};

  logic [7:0] gl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                          8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
  logic [3:0] an_tab  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] seg_tab [4] = '{8'h03, 8'h9F, 8'h25, 8'h0D};

  logic clk, rst;
  logic s_valid, c_valid, o_valid;
  frame_t s_in, c_in;
  logic [3:0] o_data;
  logic o_dp, o_blank, o_blink, o_lz;
  logic s_ready, c_ready, o_ready;
  logic [31:0] s_seg, c_seg;
  logic [7:0] s_scan, c_scan, o_seg, o_scan;
  logic [3:0] s_an, c_an;
  logic o_an;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  // Reference model state
  int     k;
  frame_t m_frame, c_act, c_sh;
  bit     c_pend;
  logic [31:0] exp_s_seg;
  logic [7:0]  exp_c_seg;
  logic [3:0]  exp_c_an;

  seg_disp_ctrl #(.DIGITS(4), .SCAN(0), .SCAN_DIV(2), .BLINK_DIV(S_BD)) u_s (
    .clk(clk), .rst(rst), .load_valid(s_valid), .load_ready(s_ready), .load_data(s_in.data),
    .load_dp(s_in.dp), .load_blank(s_in.blank), .load_blink(s_in.blink), .load_lz(s_in.lz),
    .seg_out(s_seg), .seg_scan(s_scan), .an_out(s_an)
  );

  seg_disp_ctrl #(.DIGITS(4), .SCAN(1), .SCAN_DIV(C_SD), .BLINK_DIV(C_BD)) u_c (
    .clk(clk), .rst(rst), .load_valid(c_valid), .load_ready(c_ready), .load_data(c_in.data),
    .load_dp(c_in.dp), .load_blank(c_in.blank), .load_blink(c_in.blink), .load_lz(c_in.lz),
    .seg_out(c_seg), .seg_scan(c_scan), .an_out(c_an)
  );

  seg_disp_ctrl #(.DIGITS(1), .SCAN(1), .SCAN_DIV(2), .BLINK_DIV(1000)) u_o (
    .clk(clk), .rst(rst), .load_valid(o_valid), .load_ready(o_ready), .load_data(o_data),
    .load_dp(o_dp), .load_blank(o_blank), .load_blink(o_blink), .load_lz(o_lz),
    .seg_out(o_seg), .seg_scan(o_scan), .an_out(o_an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit phase_of(input int kk, input int bd);
    return ((kk / bd) % 2) == 1;
  endfunction

  function automatic logic [7:0] render(input frame_t f, input int i, input bit ph);
    bit sup;
    sup = f.lz && (i > 0);
    for (int j = i; j < 4; j++) if (f.data[4*j +: 4] != 4'h0) sup = 0;
    if (f.blank[i]) return 8'hFF;
    if (f.blink[i] && ph) return 8'hFF;
    if (sup) return f.dp[i] ? 8'hFE : 8'hFF;
    return ~(gl[f.data[4*i +: 4]] | {7'b0, f.dp[i]});
  endfunction

  function automatic frame_t rnd_frame();
    frame_t f;
    f.data  = 16'($urandom);
    if ($urandom_range(0, 1) == 1) f.data = f.data >> (4 * $urandom_range(1, 4));
    f.dp    = 4'($urandom);
    f.blank = 4'($urandom & $urandom & $urandom);
    f.blink = 4'($urandom);
    f.lz    = 1'($urandom);
    return f;
  endfunction

  // Model: edge k moves the design from "k edges since reset" to k+1.
  initial forever begin
    int  idx;
    bit  xfer;
    @(posedge clk or posedge rst);
    if (rst) begin
      k = 0;
      m_frame = RST_FRAME;
      c_act = RST_FRAME;
      c_sh = RST_FRAME;
      c_pend = 0;
      exp_s_seg = 32'hFFFF_FFFF;
      exp_c_seg = 8'hFF;
      exp_c_an = 4'hF;
    end else begin
      for (int i = 0; i < 4; i++) exp_s_seg[8*i +: 8] = render(m_frame, i, phase_of(k, S_BD));
      if (s_valid) m_frame = s_in;
      idx = (k / C_SD) % 4;
      exp_c_seg = render(c_act, idx, phase_of(k, C_BD));
      exp_c_an = 4'hF;
      exp_c_an[idx] = 1'b0;
      xfer = c_valid && !c_pend;
      if ((k % (4 * C_SD)) == (4 * C_SD - 1) && c_pend) begin
        c_act = c_sh;
        c_pend = 0;
      end
      if (xfer) begin
        c_sh = c_in;
        c_pend = 1;
      end
      k++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("s_seg_out", s_seg, exp_s_seg);
      chk("s_unused_scan", {s_an, s_scan}, 12'hFFF);
      chk("s_ready", s_ready, !rst);
      chk("c_seg_scan", c_scan, exp_c_seg);
      chk("c_an_out", c_an, exp_c_an);
      chk("c_ready", c_ready, !rst && !c_pend);
      chk("c_unused_seg", c_seg, 32'hFFFF_FFFF);
    end
  end

  task automatic wait_an(input logic [3:0] val, output bit ok);
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (c_an == val) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_c_ready(output bit ok);
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      if (c_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    bit ok;
    int n_dark, n_lit, n_bad, n;

    vecs[0] = '{16'hDCBA, 4'b0000, 4'b0000, 1'b0, 32'h8563_C111};
    vecs[1] = '{16'h0050, 4'b0100, 4'b0000, 1'b1, 32'hFFFE_4903};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 32'hFFFF_FF03};
    vecs[3] = '{16'h3210, 4'b0000, 4'b0000, 1'b0, 32'h0D25_9F03};
    vecs[4] = '{16'h0F08, 4'b0000, 4'b1010, 1'b1, 32'hFF71_FF01};
    vecs[5] = '{16'h0007, 4'b1000, 4'b0100, 1'b1, 32'hFEFF_FF1F};
    vecs[6] = '{16'h8888, 4'b1111, 4'b0000, 1'b0, 32'h0000_0000};
    vecs[7] = '{16'hEF94, 4'b0000, 4'b0000, 1'b0, 32'h6171_0999};

    s_valid = 0; c_valid = 0; o_valid = 0;
    s_in = '0; c_in = '0;
    o_data = 4'h0; o_dp = 0; o_blank = 0; o_blink = 0; o_lz = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_c_ready", c_ready, 0);
    chk("rst_s_seg", s_seg, 32'hFFFF_FFFF);
    chk("rst_c_scan", {c_an, c_scan}, 12'hFFF);
    chk("rst_o_scan", {o_an, o_scan}, 9'h1FF);
    mon_en = 1;
    #2 rst = 0;
    @(negedge clk);
    chk("ready_after_rst", {s_ready, c_ready, o_ready}, 3'b111);
    chk("s_dark_after_rst", s_seg, 32'hFFFF_FFFF);

    // One-digit scan: every dwell wrap is a frame boundary
    o_valid = 1; o_data = 4'h5; o_dp = 1;
    @(negedge clk);
    o_valid = 0;
    chk("one_ready_drop", o_ready, 0);
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      chk("one_an", o_an, 0);
      if (o_scan == 8'h48) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("one_seg_shown", ok, 1);
    chk("one_ready_back", o_ready, 1);

    // Static directed vectors
    foreach (vecs[i]) begin
      s_in = '{data: vecs[i].data, dp: vecs[i].dp, blank: vecs[i].blank, blink: 4'h0,
               lz: vecs[i].lz};
      s_valid = 1;
      @(negedge clk);
      s_valid = 0;
      @(negedge clk);
      chk($sformatf("vec%0d_seg_out", i), s_seg, vecs[i].exp);
    end

    // Blink: digit 0 dark for half of every 2*S_BD window
    s_in = '{data: 16'h1111, dp: 4'h0, blank: 4'h0, blink: 4'b0001, lz: 1'b0};
    s_valid = 1;
    @(negedge clk);
    s_valid = 0;
    @(negedge clk);
    n_dark = 0; n_lit = 0; n_bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (s_seg[7:0] == 8'hFF) n_dark++;
      else if (s_seg[7:0] == 8'h9F) n_lit++;
      if (s_seg[31:8] != 24'h9F9F9F) n_bad++;
    end
    chk("blink_dark_cycles", n_dark, 8);
    chk("blink_lit_cycles", n_lit, 8);
    chk("blink_steady_digits", n_bad, 0);

    // Scan sequence for 3210
    c_in = '{data: 16'h3210, dp: 4'h0, blank: 4'h0, blink: 4'h0, lz: 1'b0};
    c_valid = 1;
    @(negedge clk);
    c_valid = 0;
    wait_c_ready(ok);
    chk("scan_load_done", ok, 1);
    wait_an(4'h7, ok);
    chk("scan_find_d3", ok, 1);
    wait_an(4'hE, ok);
    chk("scan_find_d0", ok, 1);
    for (int j = 0; j < 12; j++) begin
      if (j > 0) @(negedge clk);
      chk("scan_an_seq", c_an, an_tab[j / 3]);
      chk("scan_seg_seq", c_scan, seg_tab[j / 3]);
    end

    // Handshake: second frame held during pending is accepted only once ready returns
    repeat (4) @(negedge clk);
    c_in = '{data: 16'h89AB, dp: 4'h0, blank: 4'h0, blink: 4'h0, lz: 1'b0};
    c_valid = 1;
    @(negedge clk);
    chk("hs_ready_drop", c_ready, 0);
    c_in = '{data: 16'h4567, dp: 4'h0, blank: 4'h0, blink: 4'h0, lz: 1'b0};
    n = 0;
    while (!c_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hs_ready_return", c_ready, 1);
    @(negedge clk);
    c_valid = 0;
    chk("hs_second_taken", c_ready, 0);
    wait_c_ready(ok);
    chk("hs_second_applied", ok, 1);
    wait_an(4'h7, ok);
    wait_an(4'hE, ok);
    chk("hs_find_d0", ok, 1);
    chk("hs_new_digit0", c_scan, 8'h1F);

    // Randomised traffic on both multi-digit controllers
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      s_valid = 1'($urandom_range(0, 1));
      s_in = rnd_frame();
      if (!(c_valid && !c_ready)) begin
        c_valid = ($urandom_range(0, 2) == 0);
        c_in = rnd_frame();
      end
    end
    s_valid = 0;
    n = 0;
    while (c_valid && !c_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    c_valid = 0;
    chk("rand_drain", c_ready | c_pend, 1);
    c_in = '{data: 16'h3210, dp: 4'h0, blank: 4'h0, blink: 4'h0, lz: 1'b0};
    wait_c_ready(ok);
    c_valid = 1;
    @(negedge clk);
    c_valid = 0;

    // Reset during digit 2 of a scan
    wait_an(4'hB, ok);
    chk("rst_find_d2", ok, 1);
    #2 rst = 1;
    #1;
    chk("rst_async_scan", c_scan, 8'hFF);
    chk("rst_async_an", c_an, 4'hF);
    chk("rst_async_seg", s_seg, 32'hFFFF_FFFF);
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("rst_restart_an", c_an, 4'hE);
    chk("rst_restart_dark", c_scan, 8'hFF);
    repeat (3) @(negedge clk);
    chk("rst_next_an", c_an, 4'hD);
    chk("rst_next_dark", c_scan, 8'hFF);
    repeat (2) @(negedge clk);

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
